digit_serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock. It is the sequential successor of the team's 4-bit combinational `add` block. It adds a start/busy/done handshake, a subtract mode and a signed-overflow flag. It sits as a shared arithmetic unit behind a control FSM that issues one operation at a time.

---
 rtl/digit_serial_adder.sv | 150 +++++++++++++++
 tb/tb_digit_serial_adder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - multi-cycle digit-serial adder/subtractor with start/busy/done handshake
//
// Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first.
// One operation takes N = WIDTH/DIGIT RUN cycles followed by a single DONE cycle.
// A new operation may start from IDLE or from the DONE cycle.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   operation request, sampled while busy=0
//   sub    in   0: S = A + B + C_in, 1: S = A - B - C_in
//   A, B   in   WIDTH-bit operands, sampled with start
//   C_in   in   carry-in (add) / borrow-in (sub), sampled with start
//   busy   out  high while digits are being processed
//   done   out  one-cycle pulse, result valid
//   S      out  WIDTH-bit registered result
//   C_out  out  carry-out; in sub mode 1 means no borrow
//   V      out  two's-complement overflow

module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             V
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_width_check
    $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             load;
  logic             step;
  logic             last;
  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] acc_next;
  logic             c_msb;

  // Subtraction is A + ~B + ~C_in, so inverting at load time lets the
  // datapath be a plain adder for both modes.
  always_comb begin
    digit_sum = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry};
    // New digit enters at the top; the oldest digit falls off the bottom.
    acc_next  = WIDTH'({digit_sum[DIGIT-1:0], acc} >> DIGIT);
    // Carry into the top bit of the digit, recovered from a ^ b ^ sum there.
    c_msb     = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ digit_sum[DIGIT-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      C_out <= 1'b0;
      V     <= 1'b0;
    end else if (load) begin
      op_a  <= A;
      op_b  <= sub ? ~B : B;
      carry <= sub ? ~C_in : C_in;
      cnt   <= '0;
    end else if (step) begin
      op_a  <= op_a >> DIGIT;
      op_b  <= op_b >> DIGIT;
      acc   <= acc_next;
      carry <= digit_sum[DIGIT];
      cnt   <= cnt + CW'(1);
      if (last) begin
        S     <= acc_next;
        C_out <= digit_sum[DIGIT];
        V     <= digit_sum[DIGIT] ^ c_msb;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - self-checking bench for digit_serial_adder

module tb_digit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, c8, v8;
  logic [7:0] s8;

  logic       start4, sub4, cin4;
  logic [3:0] a4, b4;
  logic       busy1, done1, c1, v1;
  logic [3:0] s1;
  logic       busy4, done4, c4, v4;
  logic [3:0] s4;

  int checks = 0;
  int passes = 0;

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .A(a8), .B(b8), .C_in(cin8),
    .busy(busy8), .done(done8), .S(s8), .C_out(c8), .V(v8)
  );

  digit_serial_adder #(.WIDTH(4), .DIGIT(1)) u_dut_d1 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .A(a4), .B(b4), .C_in(cin4),
    .busy(busy1), .done(done1), .S(s1), .C_out(c1), .V(v1)
  );

  digit_serial_adder #(.WIDTH(4), .DIGIT(4)) u_dut_d4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .A(a4), .B(b4), .C_in(cin4),
    .busy(busy4), .done(done4), .S(s4), .C_out(c4), .V(v4)
  );

  // Drives one 8-bit operation from a negedge where the DUT accepts start,
  // returns at the negedge where done is high.
  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic sb,
                      input logic [7:0] es, input logic ec, input logic ev);
    logic [7:0] prev_s;
    int lat;
    prev_s = s8;
    a8 = a; b8 = b; cin8 = cin; sub8 = sb; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 20) begin
      checks++;
      if (busy8 !== 1'b1 || s8 !== prev_s)
        $display("FAIL %s_run lat=%0d busy=%b S=%h expected busy=1 S=%h", name, lat, busy8, s8, prev_s);
      else passes++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 4) $display("FAIL %s_latency got %0d expected 4", name, lat);
    else passes++;
    checks++;
    if ({busy8, s8, c8, v8} !== {1'b0, es, ec, ev})
      $display("FAIL %s_result busy=%b S=%h C=%b V=%b expected busy=0 S=%h C=%b V=%b",
               name, busy8, s8, c8, v8, es, ec, ev);
    else passes++;
  endtask

  task automatic test_reset;
    rst = 1'b1; start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b0; cin8 = 1'b1;
    start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8, s8, c8, v8} !== 12'h000)
      $display("FAIL reset_state busy=%b done=%b S=%h C=%b V=%b expected all 0", busy8, done8, s8, c8, v8);
    else passes++;
    rst = 1'b0; start8 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0)
      $display("FAIL reset_no_start busy=%b done=%b expected 0 0", busy8, done8);
    else passes++;
  endtask

  task automatic test_add;
    run8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    @(negedge clk);
    run8("add_ff_01_c", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_sub;
    run8("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    @(negedge clk);
    run8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h33; sub8 = 1'b1; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0 || s8 !== 8'h7F)
      $display("FAIL ignore_hold busy=%b done=%b S=%h expected 1 0 7f", busy8, done8, s8);
    else passes++;
    @(negedge clk);
    checks++;
    if ({done8, s8, c8, v8} !== {1'b1, 8'h03, 1'b0, 1'b0})
      $display("FAIL ignore_result done=%b S=%h C=%b V=%b expected 1 03 0 0", done8, s8, c8, v8);
    else passes++;
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0)
      $display("FAIL ignore_no_restart busy=%b done=%b expected 0 0", busy8, done8);
    else passes++;
  endtask

  task automatic test_back_to_back;
    run8("b2b_first", 8'h10, 8'h05, 1'b0, 1'b0, 8'h15, 1'b0, 1'b0);
    run8("b2b_second", 8'h20, 8'h22, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int done_seen;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy8, done8, s8, c8, v8} !== 12'h000)
      $display("FAIL midrst_clear busy=%b done=%b S=%h C=%b V=%b expected all 0", busy8, done8, s8, c8, v8);
    else passes++;
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) $display("FAIL midrst_idle activity=%0d expected 0", done_seen);
    else passes++;
    run8("midrst_after", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_exhaustive;
    int lat1, lat4, sa, sbv, sres, ref5;
    logic [4:0] exp_cs;
    logic exp_v;
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int a = 0; a < 16; a++) begin
          for (int b = 0; b < 16; b++) begin
            a4 = 4'(a); b4 = 4'(b); cin4 = c[0]; sub4 = s[0]; start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            lat1 = -1; lat4 = -1;
            for (int k = 0; k <= 6; k++) begin
              if (k > 0) @(negedge clk);
              if (done1 === 1'b1 && lat1 < 0) lat1 = k;
              if (done4 === 1'b1 && lat4 < 0) lat4 = k;
              if (lat1 >= 0 && lat4 >= 0) break;
            end
            if (s == 0) ref5 = a + b + c;
            else ref5 = a + (15 - b) + (1 - c);
            exp_cs = 5'(ref5);
            sa  = (a > 7) ? a - 16 : a;
            sbv = (b > 7) ? b - 16 : b;
            sres = (s != 0) ? sa - sbv - c : sa + sbv + c;
            exp_v = (sres > 7) || (sres < -8);
            checks++;
            if (lat1 != 4) $display("FAIL ex_d1_lat a=%0d b=%0d c=%0d s=%0d got %0d expected 4", a, b, c, s, lat1);
            else passes++;
            checks++;
            if ({c1, s1} !== exp_cs || v1 !== exp_v)
              $display("FAIL ex_d1_res a=%0d b=%0d c=%0d s=%0d CS=%h V=%b expected CS=%h V=%b",
                       a, b, c, s, {c1, s1}, v1, exp_cs, exp_v);
            else passes++;
            checks++;
            if (lat4 != 1) $display("FAIL ex_d4_lat a=%0d b=%0d c=%0d s=%0d got %0d expected 1", a, b, c, s, lat4);
            else passes++;
            checks++;
            if ({c4, s4} !== exp_cs || v4 !== exp_v)
              $display("FAIL ex_d4_res a=%0d b=%0d c=%0d s=%0d CS=%h V=%b expected CS=%h V=%b",
                       a, b, c, s, {c4, s4}, v4, exp_cs, exp_v);
            else passes++;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
